// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, frame size and glyph table for the serial 7-segment receiver
package seg7_pkg;

    localparam int FRAME_BITS = 64;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FULL
    } rx_state_t;

    // Segments are active-low in {g,f,e,d,c,b,a} order; dp (bit 7) is handled separately.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_serial_rx_if.sv
// rtl/seg7_serial_rx_if.sv - serial display link and captured-frame bundle (hex ports under SEG7_HEX_DECODE_EN)
interface seg7_serial_rx_if #(
    parameter int WIDTH = 64
);
    logic             seg_clk;
    logic             seg_sout;
    logic             SEG_PEN;
    logic             seg_clrn;
    logic [WIDTH-1:0] frame;
    logic             frame_valid;
    logic             frame_err;
    logic [6:0]       bit_cnt;
`ifdef SEG7_HEX_DECODE_EN
    logic [31:0]      hex;
    logic [7:0]       point;
    logic [7:0]       hex_ok;
`endif

    modport master (
        output seg_clk, seg_sout, SEG_PEN, seg_clrn,
`ifdef SEG7_HEX_DECODE_EN
        input  hex, point, hex_ok,
`endif
        input  frame, frame_valid, frame_err, bit_cnt
    );

    modport slave (
        input  seg_clk, seg_sout, SEG_PEN, seg_clrn,
`ifdef SEG7_HEX_DECODE_EN
        output hex, point, hex_ok,
`endif
        output frame, frame_valid, frame_err, bit_cnt
    );
endinterface

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - reverse-maps one active-low digit pattern to a hex nibble and lit dp
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [7:0] pattern,
    output logic [3:0] nibble,
    output logic       dp,
    output logic       ok
);

    always_comb begin
        nibble = 4'h0;
        ok     = 1'b0;
        dp     = ~pattern[7];
        for (int k = 0; k < 16; k++) begin
            if (pattern[6:0] == seg7_glyph(4'(k))) begin
                nibble = 4'(k);
                ok     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_serial_rx.sv
// rtl/seg7_serial_rx.sv - serial 7-segment link receiver; SEG7_HEX_DECODE_EN adds per-digit hex decode
module seg7_serial_rx
    import seg7_pkg::*;
#(
    parameter int WIDTH       = FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    seg7_serial_rx_if.slave  bus
);

    localparam logic [6:0] FULL_CNT = 7'(WIDTH);

    // Packed as {seg_clk, seg_sout, SEG_PEN, seg_clrn}
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_s;
    logic       clk_hist, pen_hist;
    logic       clk_rise, pen_rise;

    rx_state_t        state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] frame_q, frame_n;
    logic [6:0]       cnt_q, cnt_n;
    logic             overrun, overrun_n;
    logic             valid_q, valid_n;
    logic             err_q, err_n;
    logic             latch;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign clk_rise = sync_s[3] & ~clk_hist;
    assign pen_rise = sync_s[1] & ~pen_hist;

`ifdef SEG7_HEX_DECODE_EN
    localparam int DIGITS = WIDTH / 8;
    logic [31:0] hex_q, hex_n, dec_hex;
    logic [7:0]  point_q, point_n, dec_point;
    logic [7:0]  ok_q, ok_n, dec_ok;

    // Decode the frame about to be latched so hex lines up with frame_valid.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_glyph_decode u_dec (
            .pattern (frame_n[8*g +: 8]),
            .nibble  (dec_hex[4*g +: 4]),
            .dp      (dec_point[g]),
            .ok      (dec_ok[g])
        );
    end
`endif

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        frame_n   = frame_q;
        cnt_n     = cnt_q;
        overrun_n = overrun;
        valid_n   = 1'b0;
        err_n     = err_q;
        latch     = 1'b0;
        if (!sync_s[0]) begin
            shreg_n   = '0;
            cnt_n     = '0;
            overrun_n = 1'b0;
            state_n   = IDLE;
        end else begin
            if (clk_rise) begin
                shreg_n = {shreg[WIDTH-2:0], sync_s[2]};
                case (state)
                    IDLE: begin
                        cnt_n   = 7'd1;
                        state_n = (FULL_CNT == 7'd1) ? FULL : SHIFT;
                    end
                    SHIFT: begin
                        cnt_n = cnt_q + 7'd1;
                        if (cnt_q + 7'd1 == FULL_CNT) state_n = FULL;
                    end
                    default: overrun_n = 1'b1;
                endcase
            end
            // Latch sees the post-shift chain, count and overrun of this same cycle.
            if (pen_rise) begin
                latch     = 1'b1;
                frame_n   = shreg_n;
                valid_n   = 1'b1;
                err_n     = (cnt_n != FULL_CNT) | overrun_n;
                cnt_n     = '0;
                overrun_n = 1'b0;
                state_n   = IDLE;
            end
        end
`ifdef SEG7_HEX_DECODE_EN
        hex_n   = latch ? dec_hex   : hex_q;
        point_n = latch ? dec_point : point_q;
        ok_n    = latch ? dec_ok    : ok_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            clk_hist <= 1'b0;
            pen_hist <= 1'b0;
            state    <= IDLE;
            shreg    <= '0;
            frame_q  <= '0;
            cnt_q    <= '0;
            overrun  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SEG7_HEX_DECODE_EN
            hex_q    <= '0;
            point_q  <= '0;
            ok_q     <= '0;
`endif
        end else begin
            sync_q[0] <= {bus.seg_clk, bus.seg_sout, bus.SEG_PEN, bus.seg_clrn};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            clk_hist <= sync_s[3];
            pen_hist <= sync_s[1];
            state    <= state_n;
            shreg    <= shreg_n;
            frame_q  <= frame_n;
            cnt_q    <= cnt_n;
            overrun  <= overrun_n;
            valid_q  <= valid_n;
            err_q    <= err_n;
`ifdef SEG7_HEX_DECODE_EN
            hex_q    <= hex_n;
            point_q  <= point_n;
            ok_q     <= ok_n;
`endif
        end
    end

    assign bus.frame       = frame_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_err   = err_q;
    assign bus.bit_cnt     = cnt_q;
`ifdef SEG7_HEX_DECODE_EN
    assign bus.hex    = hex_q;
    assign bus.point  = point_q;
    assign bus.hex_ok = ok_q;
`endif

endmodule
